// File: rtl/spmv_row_accum_if.sv
// Bus bundle for spmv_row_accum: job control, element stream in, result writes out.
// Both streams use valid/ready: a transfer happens on a rising edge where valid && ready.
interface spmv_row_accum_if #(
    parameter int DW = 32
);
    logic          start;
    logic [DW-1:0] res_base;
    logic [DW-1:0] nrows;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_mval;
    logic [DW-1:0] in_vval;
    logic          in_last;
    logic          in_empty;
    logic          wr_en;
    logic          wr_ready;
    logic [DW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    modport slave (
        input  start, res_base, nrows, in_valid, in_mval, in_vval, in_last, in_empty, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, dbg_state
    );

    modport master (
        output start, res_base, nrows, in_valid, in_mval, in_vval, in_last, in_empty, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, dbg_state
    );
endinterface

// File: rtl/spmv_row_accum.sv
// Per-row multiply-accumulate of CSR (matrix, vector) pairs; each row's dot product
// is queued in a small FIFO and written to res_base+row under write backpressure.
module spmv_row_accum #(
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic             Clk,
    input logic             Rst,
    spmv_row_accum_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] base_q, nrows_q;
    logic [DW-1:0] rows_in_q, rows_out_q, row_idx_q;
    logic [DW-1:0] acc_q;
    logic          s1_valid_q, s1_last_q;
    logic [DW-1:0] s1_prod_q;
    logic [DW-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;

    logic          accept, push, pop, fifo_empty, elem_last;
    logic [DW-1:0] acc_next;
    logic [CW-1:0] credit_used;

    assign fifo_empty  = (count_q == '0);
    assign elem_last   = bus.in_last | bus.in_empty;
    // Row-ends sitting in stage 1 already own a FIFO slot, so no push can ever overflow.
    assign credit_used = count_q + CW'(s1_valid_q && s1_last_q);
    assign bus.in_ready = (state_q == S_RUN) && (rows_in_q != nrows_q)
                          && (credit_used < CW'(FIFO_DEPTH));
    assign accept   = bus.in_valid && bus.in_ready;
    assign push     = s1_valid_q && s1_last_q;
    assign pop      = !fifo_empty && bus.wr_ready;
    assign acc_next = acc_q + s1_prod_q;

    assign bus.wr_en     = !fifo_empty;
    assign bus.wr_addr   = fifo_empty ? '0 : fifo_addr_q[rptr_q];
    assign bus.wr_data   = fifo_empty ? '0 : fifo_data_q[rptr_q];
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = (bus.nrows == '0) ? S_DONE : S_RUN;
            S_RUN:   if (rows_in_q == nrows_q) state_d = S_DRAIN;
            S_DRAIN: if (rows_out_q == nrows_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            nrows_q    <= '0;
            rows_in_q  <= '0;
            rows_out_q <= '0;
            row_idx_q  <= '0;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_prod_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= accept;
            if (state_q == S_IDLE && bus.start) begin
                base_q     <= bus.res_base;
                nrows_q    <= bus.nrows;
                rows_in_q  <= '0;
                rows_out_q <= '0;
                row_idx_q  <= '0;
                acc_q      <= '0;
            end
            if (accept) begin
                s1_prod_q <= bus.in_empty ? '0 : bus.in_mval * bus.in_vval;
                s1_last_q <= elem_last;
                if (elem_last) rows_in_q <= rows_in_q + DW'(1);
            end
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    acc_q     <= '0;
                    row_idx_q <= row_idx_q + DW'(1);
                    wptr_q    <= wptr_q + AW'(1);
                end else begin
                    acc_q <= acc_next;
                end
            end
            if (pop) begin
                rptr_q     <= rptr_q + AW'(1);
                rows_out_q <= rows_out_q + DW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: outputs are gated by the empty flag.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= base_q + row_idx_q;
            fifo_data_q[wptr_q] <= acc_next;
        end
    end
endmodule

// File: tb/tb_spmv_row_accum.sv
// Self-checking bench for spmv_row_accum: randomized CSR row jobs against a dot-product model.
module tb_spmv_row_accum;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] m;
        logic [DW-1:0] v;
        logic          last;
        logic          empty;
    } elem_t;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    spmv_row_accum_if #(.DW(DW)) bus ();
    spmv_row_accum #(.DW(DW), .FIFO_DEPTH(4)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    elem_t         job_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_addr_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] got_addr_q[$];

    int            rdy_mode = 0;  // 0 always ready, 1 random, 2 held low
    int            hold_viol = 0;
    int            wr_en_seen = 0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_addr, prev_data;

    always @(posedge Clk) begin
        #1;
        case (rdy_mode)
            0:       bus.wr_ready = 1'b1;
            1:       bus.wr_ready = 1'($urandom_range(0, 1));
            default: bus.wr_ready = 1'b0;
        endcase
    end

    // Write monitor: logs handshakes, flags head instability under backpressure
    always @(negedge Clk) begin
        if (Rst !== 1'b0) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && (bus.wr_en !== 1'b1 || bus.wr_addr !== prev_addr || bus.wr_data !== prev_data))
                hold_viol++;
            if (bus.wr_en === 1'b1) wr_en_seen++;
            if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
                got_addr_q.push_back(bus.wr_addr);
                got_q.push_back(bus.wr_data);
            end
            prev_hold = (bus.wr_en === 1'b1) && (bus.wr_ready !== 1'b1);
            prev_addr = bus.wr_addr;
            prev_data = bus.wr_data;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic void build_expected(input logic [DW-1:0] base);
        logic [DW-1:0] acc, p, row;
        acc = '0;
        row = '0;
        exp_q.delete();
        exp_addr_q.delete();
        foreach (job_q[i]) begin
            p = job_q[i].m * job_q[i].v;
            if (!job_q[i].empty) acc = acc + p;
            if (job_q[i].last || job_q[i].empty) begin
                exp_addr_q.push_back(base + row);
                exp_q.push_back(acc);
                acc = '0;
                row = row + 1;
            end
        end
    endfunction

    function automatic elem_t mk(input logic [DW-1:0] m, input logic [DW-1:0] v,
                                 input logic l, input logic e);
        elem_t x;
        x.m = m; x.v = v; x.last = l; x.empty = e;
        return x;
    endfunction

    task automatic do_start(input logic [DW-1:0] base, input logic [DW-1:0] n);
        got_q.delete();
        got_addr_q.delete();
        bus.res_base = base;
        bus.nrows    = n;
        bus.start    = 1'b1;
        @(posedge Clk); #1;
        bus.start    = 1'b0;
    endtask

    task automatic send_elem(input elem_t e);
        int n = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge Clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_mval  = e.empty ? DW'($urandom) : e.m;
        bus.in_vval  = e.empty ? DW'($urandom) : e.v;
        bus.in_last  = e.last;
        bus.in_empty = e.empty;
        do begin @(negedge Clk); n++; end while (bus.in_ready !== 1'b1 && n < 200);
        if (bus.in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end
        @(posedge Clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin @(negedge Clk); n++; end while (bus.done !== 1'b1 && n < 500);
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: done=%b after %0d cycles, required 1", name, bus.done, n);
        end
        @(negedge Clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done: done=%b busy=%b, required 0 0", name, bus.done, bus.busy);
        end
        @(posedge Clk); #1;
    endtask

    task automatic check_writes(input string name);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: writes=%0d, required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_addr_q[i] !== exp_addr_q[i] || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                         name, i, got_addr_q[i], got_q[i], exp_addr_q[i], exp_q[i]);
            end
        end
        checks++;
        if (hold_viol !== 0) begin
            errors++;
            $display("FAIL %s_hold: stability violations=%0d, required 0", name, hold_viol);
        end
    endtask

    task automatic run_job(input string name, input logic [DW-1:0] base);
        build_expected(base);
        do_start(base, DW'(exp_q.size()));
        foreach (job_q[i]) send_elem(job_q[i]);
        wait_done(name);
        check_writes(name);
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        bus.start = 1'b0; bus.res_base = '0; bus.nrows = '0;
        bus.in_valid = 1'b0; bus.in_mval = '0; bus.in_vval = '0;
        bus.in_last = 1'b0; bus.in_empty = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        @(negedge Clk);
        checks += 7;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready); end
        if (bus.wr_en !== 1'b0)    begin errors++; $display("FAIL reset_wr_en: got %b, required 0", bus.wr_en); end
        if (bus.wr_addr !== '0)    begin errors++; $display("FAIL reset_wr_addr: got %h, required 0", bus.wr_addr); end
        if (bus.wr_data !== '0)    begin errors++; $display("FAIL reset_wr_data: got %h, required 0", bus.wr_data); end
        if (bus.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        if (bus.done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b, required 0", bus.done); end
        if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", bus.dbg_state); end
        @(posedge Clk); #1;
        Rst = 1'b0;
    endtask

    task automatic test_idle_ignore();
        bus.in_valid = 1'b1; bus.in_mval = 32'd5; bus.in_vval = 32'd5; bus.in_last = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.dbg_state !== 2'd0) begin
                errors++;
                $display("FAIL idle_ignore: in_ready=%b state=%0d, required 0 0", bus.in_ready, bus.dbg_state);
            end
        end
        @(posedge Clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic test_basic();
        job_q.delete();
        job_q.push_back(mk(91, 46, 1, 0));
        job_q.push_back(mk(37, 51, 0, 0));
        job_q.push_back(mk(69, 28, 0, 0));
        job_q.push_back(mk(100, 95, 1, 0));
        build_expected(500);
        do_start(500, 2);
        @(negedge Clk);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b, required 1", bus.busy); end
        @(posedge Clk); #1;
        foreach (job_q[i]) send_elem(job_q[i]);
        wait_done("basic");
        check_writes("basic");
    endtask

    task automatic test_empty_row();
        job_q.delete();
        job_q.push_back(mk(2, 3, 1, 0));
        job_q.push_back(mk(0, 0, 0, 1));
        job_q.push_back(mk(4, 5, 0, 0));
        job_q.push_back(mk(1, 1, 1, 0));
        run_job("empty_row", 32'd64);
    endtask

    task automatic test_overflow();
        job_q.delete();
        job_q.push_back(mk(32'hFFFF_FFFF, 2, 1, 0));
        job_q.push_back(mk(32'h8000_0000, 3, 0, 0));
        job_q.push_back(mk(32'h8000_0000, 1, 1, 0));
        run_job("overflow", 32'h1000);
    endtask

    task automatic test_zero_rows();
        int   seen0;
        logic d1, d2;
        seen0 = wr_en_seen;
        bus.res_base = 32'd77; bus.nrows = '0; bus.start = 1'b1;
        @(negedge Clk); d1 = bus.done;
        @(posedge Clk); #1; bus.start = 1'b0;
        @(negedge Clk); d2 = bus.done;
        checks++;
        if (d1 !== 1'b0 || d2 !== 1'b1) begin
            errors++;
            $display("FAIL zero_rows_done: done cycle1=%b cycle2=%b, required 0 1", d1, d2);
        end
        @(negedge Clk);
        checks++;
        if (bus.done !== 1'b0 || bus.dbg_state !== 2'd0 || wr_en_seen !== seen0) begin
            errors++;
            $display("FAIL zero_rows_after: done=%b state=%0d wr_en_cycles=%0d, required 0 0 0",
                     bus.done, bus.dbg_state, wr_en_seen - seen0);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_backpressure();
        int   n = 0;
        logic rdy_bad = 1'b0;
        job_q.delete();
        for (int i = 0; i < 6; i++) job_q.push_back(mk(DW'($urandom), DW'($urandom), 1, 0));
        build_expected(1000);
        rdy_mode = 2;
        do_start(1000, 6);
        for (int i = 0; i < 4; i++) send_elem(job_q[i]);
        bus.in_valid = 1'b1; bus.in_mval = job_q[4].m; bus.in_vval = job_q[4].v;
        bus.in_last = 1'b1; bus.in_empty = 1'b0;
        repeat (6) begin
            @(negedge Clk);
            if (bus.in_ready !== 1'b0) rdy_bad = 1'b1;
        end
        checks++;
        if (rdy_bad) begin errors++; $display("FAIL bp_credit: in_ready rose with 4 row-ends pending, required 0"); end
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== exp_addr_q[0] || bus.wr_data !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_head: wr_en=%b addr=%0d data=%h, required 1 %0d %h",
                     bus.wr_en, bus.wr_addr, bus.wr_data, exp_addr_q[0], exp_q[0]);
        end
        @(posedge Clk); #1;
        rdy_mode = 0;
        do begin @(negedge Clk); n++; end while (bus.in_ready !== 1'b1 && n < 200);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready=%b, required 1", bus.in_ready); end
        @(posedge Clk); #1;
        bus.in_valid = 1'b0;
        send_elem(job_q[5]);
        wait_done("backpressure");
        check_writes("backpressure");
    endtask

    task automatic test_random();
        rdy_mode = 1;
        for (int t = 0; t < 4; t++) begin
            int nr;
            nr = $urandom_range(1, 5);
            job_q.delete();
            for (int r = 0; r < nr; r++) begin
                int ne;
                ne = $urandom_range(0, 3);
                if (ne == 0) job_q.push_back(mk(0, 0, 0, 1));
                for (int k = 0; k < ne; k++)
                    job_q.push_back(mk(($urandom_range(0, 1) != 0) ? DW'($urandom) : DW'($urandom_range(0, 300)),
                                       DW'($urandom), (k == ne - 1), 0));
            end
            run_job($sformatf("random%0d", t), DW'($urandom_range(0, 100000)));
        end
        rdy_mode = 0;
    endtask

    task automatic test_reset_mid();
        do_start(200, 2);
        send_elem(mk(3, 4, 0, 0));
        send_elem(mk(5, 6, 0, 0));
        Rst = 1'b1;
        @(posedge Clk); #1;
        @(negedge Clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== '0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL midreset_outputs: rdy=%b wr_en=%b addr=%h data=%h busy=%b done=%b state=%0d, required all 0",
                     bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.dbg_state);
        end
        @(posedge Clk); #1;
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (got_q.size() !== 0) begin errors++; $display("FAIL midreset_nowrite: writes=%0d, required 0", got_q.size()); end
        job_q.delete();
        job_q.push_back(mk(7, 9, 1, 0));
        run_job("after_reset", 32'd300);
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_basic();
        test_empty_row();
        test_overflow();
        test_zero_rows();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spmv_row_accum.md
Name: spmv_row_accum

Overview:
- Downstream consumer of the HHT `control` fetch stage.
- Accepts the stream of (matrix value, vector value) pairs that `control` gathers from CSR storage, tagged with row-end and empty-row markers.
- Multiplies and accumulates each pair per row, then writes each row's dot product y[row] to result memory at res_base+row through a small output FIFO with write-side backpressure.
- Signals done after nrows results have been written.

Parameters:
DW, 32, data/address width
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
Clk  in  1  clock; all logic on rising edge
Rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; latches res_base/nrows, begins job (ignored unless IDLE)
res_base  in  DW  result memory base address
nrows  in  DW  number of rows in job
in_valid  in  1  element valid
in_ready  out  1  element accepted when in_valid&&in_ready
in_mval  in  DW  matrix nonzero value
in_vval  in  DW  gathered vector value
in_last  in  1  element is last nonzero of current row
in_empty  in  1  row has zero nonzeros; mval/vval ignored, in_last implied
wr_en  out  1  result write valid (FIFO head present)
wr_ready  in  1  memory accepts write this cycle
wr_addr  out  DW  res_base + row index
wr_data  out  DW  row result
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after final write handshake

Behaviour:
- Reset: state IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0. Accumulator, row counters, pipeline valids and FIFO are cleared.
- Reset mid-job discards all in-flight data; no further writes occur.
- States: IDLE -> RUN on start. RUN -> DRAIN when rows_in==nrows (final row-end accepted). DRAIN -> DONE when rows_out==nrows. DONE -> IDLE next cycle, with done=1 in that DONE cycle.
- start with nrows==0: IDLE -> DONE -> IDLE. done is asserted 2 cycles after start and no writes occur.
- Stage 1 (registered on accept): prod = (in_mval*in_vval)[DW-1:0]. prod=0 when in_empty. The last flag is in_last|in_empty.
- Stage 2: acc_next = acc + prod, modulo 2^DW.
  - If last: push {res_base+row_idx, acc_next} into the FIFO, clear acc, and increment row_idx.
  - Otherwise: acc <= acc_next.
- Latency: an element accepted at cycle T that closes a row produces wr_en=1 at T+2 if the FIFO was empty.
- Credit rule:
  - in_ready = (state==RUN) && (fifo_count + row_ends_in_stage1_and_2 < FIFO_DEPTH).
  - The FIFO never overflows; no data is dropped or stalled inside the pipeline.
- FIFO:
  - Head drives wr_addr/wr_data; wr_en = !empty.
  - Pop on wr_en&&wr_ready.
  - Simultaneous push and pop in one cycle keeps the count unchanged; a push into a full FIFO is impossible by the credit rule.
  - wr_addr/wr_data hold stable while wr_en&&!wr_ready.
- in_valid while not RUN is ignored (in_ready=0). Elements beyond nrows rows are never accepted.
- Row index counters are DW bits wide; wrap is not supported (nrows < 2^DW).
- start while busy is ignored.

Test Plan:
- Reset, then start with res_base=500, nrows=2.
  - Row0: (91,46,last).
  - Row1: (37,51), (69,28), (100,95,last).
  - Expect writes addr500=4186, addr501=13319; done pulse; busy low after.
- Empty row: nrows=3, rows {(2,3,last)}, {empty}, {(4,5),(1,1,last)} -> writes 6, 0, 21 at base..base+2.
- Backpressure: hold wr_ready=0 while streaming 6 single-element rows.
  - in_ready must drop after 4 row-ends are outstanding.
  - wr_addr/wr_data stay stable; release wr_ready and all 6 writes complete in order.
- Overflow: (0xFFFFFFFF,2,last) then (0x80000000,3),(0x80000000,1,last) -> 0xFFFFFFFE, 0x00000000.
- nrows=0 start -> done exactly 2 cycles later, wr_en never asserted.
- Assert Rst mid-row after 2 elements -> all outputs return to reset values. A fresh start with nrows=1, (7,9,last) writes 63 (no stale accumulation).
